// File: rtl/generic_waveform_reader.sv
// rtl/generic_waveform_reader.sv - AXI4 read master streaming a circular waveform buffer out of DDR
// Optional feature macro: WAVEFORM_READER_DIAG_EN (output word counter on outData[31:0] plus diagSeqErr)
`timescale 1ns/1ps
module generic_waveform_reader #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int FIFO_CAPACITY  = 64,
    parameter int BURST_LEN      = 8,
    parameter int ACQ_CAPACITY   = 1 << 23
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [AXI_ADDR_WIDTH-1:0]         baseAddr,
    input  logic [$clog2(ACQ_CAPACITY)-1:0]   startIndex,
    input  logic [$clog2(ACQ_CAPACITY):0]     readCount,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        rrespErr,
    output logic [AXI_ADDR_WIDTH-1:0]         axi_ARADDR,
    output logic [7:0]                        axi_ARLEN,
    output logic [2:0]                        axi_ARSIZE,
    output logic                              axi_ARVALID,
    input  logic                              axi_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]         axi_RDATA,
    input  logic [1:0]                        axi_RRESP,
    input  logic                              axi_RLAST,
    input  logic                              axi_RVALID,
    output logic                              axi_RREADY,
    output logic [AXI_DATA_WIDTH-1:0]         outData,
    output logic                              outValid,
    input  logic                              outReady
`ifdef WAVEFORM_READER_DIAG_EN
    ,
    output logic                              diagSeqErr
`endif
);

    localparam int IDX_W    = $clog2(ACQ_CAPACITY);
    localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam int BASE_LSB = IDX_W + ADDR_LSB;
    localparam int BASE_W   = AXI_ADDR_WIDTH - BASE_LSB;
    localparam int FA_W     = $clog2(FIFO_CAPACITY);
    localparam int FC_W     = FA_W + 1;
    localparam int BL_W     = $clog2(BURST_LEN) + 1;

    localparam logic [IDX_W:0] LAST_BURST_START = (IDX_W + 1)'(ACQ_CAPACITY - BURST_LEN);
    localparam logic [IDX_W:0] BURST_LEN_IDX    = (IDX_W + 1)'(BURST_LEN);
    localparam logic [FC_W:0]  FIFO_CAP_EXT     = (FC_W + 1)'(FIFO_CAPACITY);
    localparam logic [FC_W:0]  BURST_LEN_CRED   = (FC_W + 1)'(BURST_LEN);
    localparam logic [7:0]     MULTI_LEN        = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          read_addr_q;
    logic [IDX_W:0]            words_left_q;
    logic [BASE_W-1:0]         base_q;
    logic [7:0]                arlen_q;
    logic [BL_W-1:0]           beats_left_q;
    logic                      err_q, abort_q, done_q;
    logic [1:0]                rresp_err_q;
    logic [AXI_DATA_WIDTH-1:0] fifo_mem [FIFO_CAPACITY];
    logic [FA_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [FC_W-1:0]           fifo_cnt_q;

    logic                      abort_act, beat, last_exp, rlast_bad, beat_err, burst_end;
    logic                      fifo_push, fifo_pop, flush, done_d, issue, multi_ok;
    logic [7:0]                issue_len;
    logic [FC_W:0]             credit;
    logic                      unused_base_bits;

    // Low base address bits are replaced by the word index and byte offset.
    assign unused_base_bits = ^baseAddr[BASE_LSB-1:0];

    assign abort_act = abort_q || abort;
    assign beat      = (state_q == S_DATA) && axi_RVALID;
    assign last_exp  = (beats_left_q == BL_W'(1));
    assign rlast_bad = (axi_RLAST != last_exp);
    assign beat_err  = beat && ((axi_RRESP != 2'b00) || rlast_bad);
    assign burst_end = beat && (axi_RLAST || last_exp);
    assign fifo_push = beat && !abort_act;
    assign fifo_pop  = outValid && outReady;
    // Beats already requested but not yet received occupy FIFO slots in advance.
    assign credit    = FIFO_CAP_EXT - (FC_W + 1)'(fifo_cnt_q) - (FC_W + 1)'(beats_left_q);
    assign multi_ok  = (words_left_q >= BURST_LEN_IDX) && ({1'b0, read_addr_q} <= LAST_BURST_START)
                       && (credit >= BURST_LEN_CRED);

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign rrespErr    = rresp_err_q;
    assign axi_ARADDR  = {base_q, read_addr_q, {ADDR_LSB{1'b0}}};
    assign axi_ARLEN   = arlen_q;
    assign axi_ARSIZE  = 3'(ADDR_LSB);
    assign axi_ARVALID = (state_q == S_ADDR);
    assign axi_RREADY  = (state_q == S_DATA);
    assign outValid    = (fifo_cnt_q != '0) && !abort_q;

    // Next-state selection, burst choice, flush and completion pulse.
    always_comb begin
        state_d   = state_q;
        flush     = 1'b0;
        done_d    = 1'b0;
        issue     = 1'b0;
        issue_len = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (readCount == '0) done_d = 1'b1;
                    else                 state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_act) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (words_left_q == '0) begin
                    state_d = S_DONE;
                end else if (multi_ok) begin
                    issue     = 1'b1;
                    issue_len = MULTI_LEN;
                    state_d   = S_ADDR;
                end else if (credit != '0) begin
                    issue   = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi_ARREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (burst_end) begin
                    if (abort_act) begin
                        state_d = S_IDLE;
                        flush   = 1'b1;
                    end else if (err_q || beat_err) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (abort_act) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (fifo_cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Read pointers, word count, error capture and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_addr_q  <= '0;
            words_left_q <= '0;
            base_q       <= '0;
            arlen_q      <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            done_q       <= 1'b0;
            rresp_err_q  <= 2'b00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            done_q <= done_d;
            if (state_q == S_IDLE && start) begin
                read_addr_q  <= startIndex;
                words_left_q <= readCount;
                base_q       <= baseAddr[AXI_ADDR_WIDTH-1:BASE_LSB];
                rresp_err_q  <= 2'b00;
                err_q        <= 1'b0;
            end
            if (state_d == S_IDLE)                  abort_q <= 1'b0;
            else if (abort && state_q != S_IDLE)    abort_q <= 1'b1;
            if (issue) begin
                arlen_q      <= issue_len;
                beats_left_q <= BL_W'(issue_len) + BL_W'(1);
            end
            if (beat) begin
                read_addr_q  <= read_addr_q + 1'b1;
                words_left_q <= words_left_q - 1'b1;
                beats_left_q <= burst_end ? '0 : beats_left_q - 1'b1;
                if (beat_err) err_q <= 1'b1;
                if (rresp_err_q == 2'b00) begin
                    if (axi_RRESP != 2'b00) rresp_err_q <= axi_RRESP;
                    else if (rlast_bad)     rresp_err_q <= 2'b10;
                end
            end
            if (flush) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fifo_cnt_q <= '0;
            end else begin
                if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                fifo_cnt_q <= fifo_cnt_q + FC_W'(fifo_push) - FC_W'(fifo_pop);
            end
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (fifo_push && !flush) fifo_mem[wr_ptr_q] <= axi_RDATA;
    end

`ifdef WAVEFORM_READER_DIAG_EN
    logic [31:0] diag_cnt_q, diag_exp_q;
    logic        diag_first_q, diag_err_q;

    // Output word counter and recorder sequence check on incoming words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_cnt_q   <= '0;
            diag_exp_q   <= '0;
            diag_first_q <= 1'b1;
            diag_err_q   <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            diag_cnt_q   <= '0;
            diag_first_q <= 1'b1;
            diag_err_q   <= 1'b0;
        end else begin
            if (fifo_pop) diag_cnt_q <= diag_cnt_q + 1'b1;
            if (fifo_push) begin
                diag_first_q <= 1'b0;
                if (diag_first_q) begin
                    diag_exp_q <= axi_RDATA[31:0] + 1'b1;
                end else begin
                    if (axi_RDATA[31:0] != diag_exp_q) diag_err_q <= 1'b1;
                    diag_exp_q <= diag_exp_q + 1'b1;
                end
            end
        end
    end

    assign outData    = {fifo_mem[rd_ptr_q][AXI_DATA_WIDTH-1:32], diag_cnt_q};
    assign diagSeqErr = diag_err_q;
`else
    assign outData = fifo_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_generic_waveform_reader.sv
// tb/tb_generic_waveform_reader.sv - self-checking bench for generic_waveform_reader
`timescale 1ns/1ps
module tb_generic_waveform_reader;

    localparam int AW = 32, DW = 128, FC = 64, BL = 8, ACQ = 256, IW = 8;
    localparam logic [31:0] BASE_HI = 32'h1234_5000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic [AW-1:0] baseAddr = 32'h1234_5ABC;
    logic [IW-1:0] startIndex = '0;
    logic [IW:0]   readCount = '0;
    logic          busy, done;
    logic [1:0]    rrespErr;
    logic [AW-1:0] axi_ARADDR;
    logic [7:0]    axi_ARLEN;
    logic [2:0]    axi_ARSIZE;
    logic          axi_ARVALID, axi_ARREADY, axi_RLAST, axi_RVALID, axi_RREADY;
    logic [DW-1:0] axi_RDATA, outData;
    logic [1:0]    axi_RRESP;
    logic          outValid, outReady;

    always #5 clk = ~clk;

    generic_waveform_reader #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .FIFO_CAPACITY(FC),
        .BURST_LEN(BL), .ACQ_CAPACITY(ACQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .baseAddr(baseAddr),
        .startIndex(startIndex), .readCount(readCount), .busy(busy), .done(done),
        .rrespErr(rrespErr), .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN),
        .axi_ARSIZE(axi_ARSIZE), .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY),
        .axi_RDATA(axi_RDATA), .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST),
        .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY), .outData(outData),
        .outValid(outValid), .outReady(outReady)
    );

    typedef struct {
        int sidx; int cnt; bit slow; bit abort_with_start; int err_burst; int err_beat;
        int exp_ar; int exp_words; int exp_done; logic [1:0] exp_rresp;
    } vec_t;

    int n_checks = 0, n_fail = 0;
    bit slow = 0;
    int err_burst = 0, err_beat = 0;
    int s_beats = 0, s_bursts = 0, two_outstanding = 0;
    bit have_burst = 0;
    int b_idx = 0, b_len = 0, b_beat = 0;
    logic [31:0] ar_addr_log[$];
    int ar_len_log[$];
    logic [DW-1:0] got[$];
    int done_cnt = 0;

    function automatic logic [DW-1:0] word_of(input int idx);
        return {32'hC0DE_0000 | 32'(idx), 32'h5A5A_5A5A, ~32'(idx), 32'(idx)};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI read slave: memory word i holds word_of(i); handshakes sampled mid-cycle, applied after the edge
    initial begin
        bit ar_fire, r_fire;
        logic [31:0] ar_a;
        int ar_l;
        axi_ARREADY = 1'b1; axi_RVALID = 1'b0; axi_RLAST = 1'b0;
        axi_RRESP = 2'b00; axi_RDATA = '0;
        forever begin
            @(negedge clk);
            ar_fire = axi_ARVALID && axi_ARREADY;
            r_fire  = axi_RVALID && axi_RREADY;
            ar_a    = axi_ARADDR;
            ar_l    = int'(axi_ARLEN);
            @(posedge clk); #1;
            if (!rst_n) begin
                have_burst = 0;
            end else begin
                if (r_fire) begin
                    s_beats++;
                    b_beat++;
                    b_idx = (b_idx + 1) % ACQ;
                    if (b_beat > b_len) have_burst = 0;
                end
                if (ar_fire) begin
                    if (have_burst) two_outstanding++;
                    ar_addr_log.push_back(ar_a);
                    ar_len_log.push_back(ar_l);
                    have_burst = 1;
                    b_idx = int'((ar_a >> 4) & 32'hFF);
                    b_len = ar_l;
                    b_beat = 0;
                    s_bursts++;
                end
            end
            axi_RVALID  = have_burst && !(slow && $urandom_range(0, 2) == 0);
            axi_RDATA   = word_of(b_idx);
            axi_RLAST   = have_burst && (b_beat == b_len);
            axi_RRESP   = (s_bursts == err_burst && b_beat == err_beat - 1) ? 2'b10 : 2'b00;
            axi_ARREADY = slow ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream consumer and done-pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (outValid && outReady) got.push_back(outData);
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_run();
        got.delete(); ar_addr_log.delete(); ar_len_log.delete();
        done_cnt = 0; s_beats = 0; s_bursts = 0; two_outstanding = 0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        for (c = 0; c < 5000 && !(!busy && c >= 3); c++) @(negedge clk);
        check({name, "_timeout"}, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int idx, left, len, bad;
        clear_run();
        slow = v.slow; err_burst = v.err_burst; err_beat = v.err_beat; outReady = 1'b1;
        @(posedge clk); #1;
        startIndex = IW'(v.sidx); readCount = (IW+1)'(v.cnt); start = 1'b1; abort = v.abort_with_start;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        wait_idle(name);
        check({name, "_done"}, 32'(done_cnt), 32'(v.exp_done));
        check({name, "_rresp"}, rrespErr, v.exp_rresp);
        check({name, "_words"}, 32'(got.size()), 32'(v.exp_words));
        check({name, "_ars"}, 32'(ar_addr_log.size()), 32'(v.exp_ar));
        check({name, "_outstanding"}, 32'(two_outstanding), 32'd0);
        bad = 0;
        for (int n = 0; n < got.size() && n < v.exp_words; n++)
            if (got[n] !== word_of((v.sidx + n) % ACQ)) bad++;
        check({name, "_data_bad"}, 32'(bad), 32'd0);
        idx = v.sidx; left = v.cnt;
        for (int k = 0; k < v.exp_ar && k < ar_addr_log.size(); k++) begin
            len = (left >= BL && idx <= ACQ - BL) ? BL - 1 : 0;
            check($sformatf("%s_araddr%0d", name, k), ar_addr_log[k], BASE_HI | 32'(idx << 4));
            check($sformatf("%s_arlen%0d", name, k), 32'(ar_len_log[k]), 32'(len));
            idx = (idx + len + 1) % ACQ;
            left -= len + 1;
        end
        slow = 0; err_burst = 0;
    endtask

    vec_t vecs[7];

    initial begin
        int c, bad;
        vecs[0] = '{sidx: 0,   cnt: 20, slow: 0, abort_with_start: 0, err_burst: 0, err_beat: 0, exp_ar: 6, exp_words: 20, exp_done: 1, exp_rresp: 2'b00};
        vecs[1] = '{sidx: 253, cnt: 11, slow: 0, abort_with_start: 0, err_burst: 0, err_beat: 0, exp_ar: 4, exp_words: 11, exp_done: 1, exp_rresp: 2'b00};
        vecs[2] = '{sidx: 0,   cnt: 40, slow: 0, abort_with_start: 0, err_burst: 2, err_beat: 3, exp_ar: 2, exp_words: 16, exp_done: 1, exp_rresp: 2'b10};
        vecs[3] = '{sidx: 100, cnt: 5,  slow: 0, abort_with_start: 0, err_burst: 0, err_beat: 0, exp_ar: 5, exp_words: 5,  exp_done: 1, exp_rresp: 2'b00};
        vecs[4] = '{sidx: 245, cnt: 16, slow: 0, abort_with_start: 0, err_burst: 0, err_beat: 0, exp_ar: 9, exp_words: 16, exp_done: 1, exp_rresp: 2'b00};
        vecs[5] = '{sidx: 0,   cnt: 0,  slow: 0, abort_with_start: 0, err_burst: 0, err_beat: 0, exp_ar: 0, exp_words: 0,  exp_done: 1, exp_rresp: 2'b00};
        vecs[6] = '{sidx: 10,  cnt: 30, slow: 1, abort_with_start: 1, err_burst: 0, err_beat: 0, exp_ar: 9, exp_words: 30, exp_done: 1, exp_rresp: 2'b00};
        outReady = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_arvalid", axi_ARVALID, 1'b0);
        check("rst_rready", axi_RREADY, 1'b0);
        check("rst_outvalid", outValid, 1'b0);
        check("rst_rresp", rrespErr, 2'b00);
        check("rst_araddr", axi_ARADDR, 32'h0);
        check("rst_arlen", axi_ARLEN, 8'h0);
        check("rst_arsize", axi_ARSIZE, 3'd4);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // readCount=0: done exactly one cycle after start, no address traffic
        clear_run();
        @(posedge clk); #1;
        readCount = '0; startIndex = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done_now", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("zero_done_once", done, 1'b0);
        check("zero_no_ar", 32'(ar_addr_log.size()), 32'd0);

        // Abort in the data phase of the first burst
        clear_run();
        @(posedge clk); #1;
        startIndex = 8'd0; readCount = 9'd40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 0; c < 200 && s_beats < 3; c++) @(negedge clk);
        check("abort_reach_data", 32'(s_beats >= 3), 32'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle("abort");
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_outvalid", outValid, 1'b0);
        check("abort_beats_drained", 32'(s_beats), 32'd8);
        check("abort_one_ar", 32'(ar_addr_log.size()), 32'd1);
        check("abort_slave_idle", 32'(have_burst), 32'd0);
        run_vec(vecs[0], "after_abort");

        // Back-pressure: fetching stops at FIFO capacity, then resumes intact
        clear_run();
        outReady = 1'b0;
        @(posedge clk); #1;
        startIndex = 8'd0; readCount = 9'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("stall_beats", 32'(s_beats), 32'd64);
        check("stall_ars", 32'(ar_addr_log.size()), 32'd8);
        check("stall_arvalid", axi_ARVALID, 1'b0);
        check("stall_outvalid", outValid, 1'b1);
        check("stall_busy", busy, 1'b1);
        @(posedge clk); #1 outReady = 1'b1;
        wait_idle("stall");
        check("stall_words", 32'(got.size()), 32'd200);
        bad = 0;
        for (int n = 0; n < got.size(); n++) if (got[n] !== word_of(n % ACQ)) bad++;
        check("stall_data_bad", 32'(bad), 32'd0);
        check("stall_done", 32'(done_cnt), 32'd1);
        check("stall_rresp", rrespErr, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
